// File: rtl/span_fetcher.sv
// Span fetcher: turns a horizontal span command into VRAM word reads and emits
// destination-aligned 32-pixel windows with valid mask and shift for the shift aligner.
module span_fetcher #(
    parameter int ADDR_W = 20,
    parameter int X_W    = 10
) (
    input  logic              clk_draw,
    input  logic              rst_draw,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [X_W-1:0]    cmd_dst,
    input  logic [X_W:0]      cmd_len,
    output logic              mem_req,
    output logic [ADDR_W-5:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [127:0]      mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [255:0]      unaligned_pixels,
    output logic [31:0]       unaligned_valid_mask,
    output logic [3:0]        alignment_shift,
    output logic [X_W-5:0]    out_dst_word,
    output logic              out_last,
    output logic              busy
);
    localparam int WA_W   = ADDR_W - 4;
    localparam int DW_W   = X_W - 4;
    localparam int LEFT_W = X_W - 2;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ, WAIT, EMIT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [X_W:0]      len_q, len_d;
    logic [3:0]        shift_q, shift_d;
    logic [WA_W-1:0]   word_q, word_d;
    logic [DW_W-1:0]   dstw_q, dstw_d;
    logic [LEFT_W-1:0] left_q, left_d;
    logic [127:0]      prev_q, prev_d;
    logic [255:0]      pix_q, pix_d;
    logic [31:0]       mask_q, mask_d;
    logic              last_q, last_d;

    logic              accept;
    logic [ADDR_W-1:0] acceptBase;
    logic [X_W+1:0]    acceptSpan;
    logic [ADDR_W-1:0] winRel;
    logic [ADDR_W-1:0] winOff;
    logic [31:0]       winMask;

    assign cmd_ready  = (state_q == IDLE) && !rst_draw;
    assign accept     = cmd_valid && cmd_ready;
    assign acceptBase = cmd_src - ADDR_W'(cmd_dst[3:0]);
    assign acceptSpan = (X_W+2)'(cmd_dst[3:0]) + (X_W+2)'(cmd_len) - (X_W+2)'(1);

    assign busy                 = (state_q != IDLE);
    assign out_valid            = (state_q == EMIT);
    assign mem_req              = (state_q == REQ0) || (state_q == REQ);
    assign mem_addr             = (state_q == REQ0) ? word_q :
                                  (state_q == REQ)  ? word_q + WA_W'(1) : '0;
    assign unaligned_pixels     = pix_q;
    assign unaligned_valid_mask = mask_q;
    assign alignment_shift      = shift_q;
    assign out_dst_word         = dstw_q;
    assign out_last             = last_q;

    // A window pixel belongs to the span when its distance past src, taken
    // modulo the address space, is below len; this also clears wrapped reads.
    always_comb begin
        winRel  = {word_q, 4'b0000} - src_q;
        winOff  = '0;
        winMask = '0;
        for (int j = 0; j < 32; j++) begin
            winOff     = winRel + ADDR_W'(j);
            winMask[j] = (winOff < ADDR_W'(len_q));
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        len_d   = len_q;
        shift_d = shift_q;
        word_d  = word_q;
        dstw_d  = dstw_q;
        left_d  = left_q;
        prev_d  = prev_q;
        pix_d   = pix_q;
        mask_d  = mask_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    src_d   = cmd_src;
                    len_d   = cmd_len;
                    shift_d = cmd_src[3:0] - cmd_dst[3:0];
                    word_d  = WA_W'(acceptBase >> 4);
                    dstw_d  = cmd_dst[X_W-1:4];
                    left_d  = LEFT_W'(acceptSpan >> 4);
                    if (cmd_len != '0) begin
                        state_d = REQ0;
                    end
                end
            end
            REQ0: begin
                if (mem_ack) begin
                    state_d = WAIT0;
                end
            end
            WAIT0: begin
                if (mem_rvalid) begin
                    prev_d  = mem_rdata;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    pix_d   = {mem_rdata, prev_q};
                    mask_d  = winMask;
                    last_d  = (left_q == '0);
                    prev_d  = mem_rdata;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        word_d  = word_q + WA_W'(1);
                        dstw_d  = dstw_q + DW_W'(1);
                        left_d  = left_q - LEFT_W'(1);
                        state_d = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            state_q <= IDLE;
            src_q   <= '0;
            len_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            dstw_q  <= '0;
            left_q  <= '0;
            prev_q  <= '0;
            pix_q   <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            len_q   <= len_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            dstw_q  <= dstw_d;
            left_q  <= left_d;
            prev_q  <= prev_d;
            pix_q   <= pix_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: doc/span_fetcher.md
Name: span_fetcher

Overview:
Upstream feeder for the shift aligner in the draw pipeline. It accepts a horizontal span command (source pixel address, destination x, length), reads 16-pixel source words from VRAM, and emits one beat per destination-aligned 16-pixel word. Each beat carries the 32-pixel unaligned window, the 32-bit valid mask and the 4-bit alignment shift. The shift aligner registers these directly.

Parameters:
ADDR_W, 20, source pixel address width (8-bit pixels, 16 per 128-bit word); word address is ADDR_W-4 bits
X_W, 10, destination x width; cmd_len is X_W+1 bits

Ports:
clk_draw  in  1  draw clock
rst_draw  in  1  reset, synchronous, active-high
cmd_valid  in  1  span command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_src  in  ADDR_W  first source pixel address
cmd_dst  in  X_W  first destination x
cmd_len  in  X_W+1  pixel count, 0 allowed
mem_req  out  1  read request
mem_addr  out  ADDR_W-4  source word address
mem_ack  in  1  request accepted this cycle
mem_rvalid  in  1  read data returned
mem_rdata  in  128  source word; pixel p in bits [8p+7:8p]
out_valid  out  1  beat valid
out_ready  in  1  downstream accepts beat
unaligned_pixels  out  256  {later word, earlier word}
unaligned_valid_mask  out  32  bit j set if window pixel j is inside the span
alignment_shift  out  4  (cmd_src[3:0] - cmd_dst[3:0]) mod 16
out_dst_word  out  X_W-4  destination word index, cmd_dst>>4 + k
out_last  out  1  final beat of span
busy  out  1  span in progress

Behaviour:
- Reset values: cmd_ready=0 during the reset cycle, then 1 in IDLE. mem_req=0, mem_addr=0, out_valid=0, all data outputs 0, out_last=0, busy=0.
- Per-command values, latched on accept:
  - shift S = (src[3:0]-dst[3:0]) mod 16
  - first word F = ((src - dst[3:0]) mod 2^ADDR_W) >> 4
  - beats N = ((dst[3:0] + len - 1) >> 4) + 1
  - source words fetched: F..F+N, modulo 2^(ADDR_W-4). Wrapped reads are legal; the mask clears their pixels.
- Mask for beat k, window pixel j:
  - idx = 16*(F+k) + j
  - bit set iff ((idx - src) mod 2^ADDR_W) < len
- States:
  - IDLE: cmd_ready=1. Accept with len=0: stay IDLE, no reads, no beats. Accept with len>0: go to REQ0.
  - REQ0: mem_req=1, mem_addr=F, held until mem_ack. Then WAIT0.
  - WAIT0: on mem_rvalid store word as prev, go to REQ.
  - REQ: mem_req=1, mem_addr=F+k+1, held until mem_ack. Then WAIT.
  - WAIT: on mem_rvalid, register the beat: pixels={rdata,prev}, mask, S, dst word, out_last=(k==N-1). prev<=rdata. Go to EMIT.
  - EMIT: out_valid=1. All beat outputs stay stable until out_ready. On accept: if last go to IDLE, else k++ and go to REQ.
- Only one read is ever outstanding. mem_rvalid is ignored outside WAIT0/WAIT.
- busy=1 in every state except IDLE. cmd_ready=0 while busy.
- Minimum beat spacing is 1 (req) + memory latency + 1 (emit), so out_valid is never asserted on consecutive beats without a gap.
- Reset mid-span aborts immediately to IDLE. A late mem_rvalid after reset is dropped.
- Wrap: F+k arithmetic is modulo word space. out_dst_word is modulo 2^(X_W-4).

Test Plan:
- Reset: assert rst_draw 2 cycles mid-WAIT, then return one mem_rvalid. Required: outputs stay at reset values, state IDLE, no beat emitted.
- Aligned span, src=0x40, dst=0x20, len=32, zero-latency memory, out_ready=1. Required:
  - reads at word addresses 4, 5, 6
  - beat0: S=0, mask 0xFFFFFFFF, dst_word 2, last=0
  - beat1: mask 0x0000FFFF, dst_word 3, last=1
- Misaligned span, src=0x103, dst=5, len=20. Required:
  - S=14, reads 0xF, 0x10, 0x11
  - beat0: mask 0xFFF80000, dst_word 0
  - beat1: mask 0x007FFFF8, last=1
  - pixels = {word 0x10, word 0xF}, then {word 0x11, word 0x10}
- Backpressure: same as the misaligned span with out_ready low for 5 cycles on beat0. Required: all beat outputs stable, no mem_req issued until accept.
- Length 0 and wrap:
  - len=0: accepted, no mem_req, no out_valid, busy stays 0.
  - src=0x00002, dst=4, len=3: F wraps to 0xFFFF, reads 0xFFFF then 0x0000, beat0 mask 0x00040000 | 0x00180000 (bits 18..20), S=14.
- Random-latency memory (0–7 cycles of ack and rvalid delay) with 200 random spans against a reference model. Required: exact beat count, masks and pixel data; shift-aligner output equals destination pixels.
